// File: rtl/spi_slave_scheduler_if.sv
// Client/engine-side bundle of the SPI slave scheduler.
// master = scheduler, slave = clients and shift engine.
interface spi_slave_scheduler_if #(
    parameter int CODE_SIZE = 2
);
    logic                 req_lev;
    logic                 req_stage;
    logic                 spi_done;
    logic [CODE_SIZE-1:0] SPI_Code;
    logic                 spi_start;
    logic                 done_lev;
    logic                 done_stage;
    logic                 err_timeout;
    logic                 busy;

    modport master (
        input  req_lev,
        input  req_stage,
        input  spi_done,
        output SPI_Code,
        output spi_start,
        output done_lev,
        output done_stage,
        output err_timeout,
        output busy
    );

    modport slave (
        output req_lev,
        output req_stage,
        output spi_done,
        input  SPI_Code,
        input  spi_start,
        input  done_lev,
        input  done_stage,
        input  err_timeout,
        input  busy
    );
endinterface

// File: rtl/spi_slave_scheduler.sv
// Round-robin scheduler sharing one SPI shift engine between lev and stage.
// Sequence: select code, setup hold, start pulse, transfer, guard gap.
module spi_slave_scheduler #(
    parameter int CODE_SIZE      = 2,
    parameter int SETUP_CYCLES   = 2,
    parameter int GUARD_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_slave_scheduler_if.master        bus
);
    localparam int MAX_SG = (SETUP_CYCLES > GUARD_CYCLES) ?
                            SETUP_CYCLES : GUARD_CYCLES;
    localparam int MAXC   = (TIMEOUT_CYCLES > MAX_SG) ?
                            TIMEOUT_CYCLES : MAX_SG;
    localparam int CW     = $clog2(MAXC);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [CODE_SIZE-1:0] CODE_NONE  = '0;
    localparam logic [CODE_SIZE-1:0] CODE_LEV   = CODE_SIZE'(1);
    localparam logic [CODE_SIZE-1:0] CODE_STAGE = CODE_SIZE'(2);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        XFER,
        GUARD
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 fav_stage_q, fav_stage_d;
    logic [CODE_SIZE-1:0] code_q, code_d;
    logic                 start_q, start_d;
    logic                 dlev_q, dlev_d;
    logic                 dstg_q, dstg_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 grant_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            fav_stage_q <= 1'b0;
            code_q      <= CODE_NONE;
            start_q     <= 1'b0;
            dlev_q      <= 1'b0;
            dstg_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            fav_stage_q <= fav_stage_d;
            code_q      <= code_d;
            start_q     <= start_d;
            dlev_q      <= dlev_d;
            dstg_q      <= dstg_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // owner_q: 1 = stage; fav_stage_q: stage wins a tie
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        fav_stage_d = fav_stage_q;
        code_d      = code_q;
        start_d     = 1'b0;
        dlev_d      = 1'b0;
        dstg_d      = 1'b0;
        err_d       = 1'b0;
        grant_stage = bus.req_stage &
                      (~bus.req_lev | fav_stage_q);

        unique case (state_q)
            IDLE: begin
                if (bus.req_lev || bus.req_stage) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    owner_d = grant_stage;
                    code_d  = grant_stage ? CODE_STAGE : CODE_LEV;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = START;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            START: begin
                state_d = XFER;
                cnt_d   = '0;
            end
            XFER: begin
                if (bus.spi_done || cnt_q == TO_LAST) begin
                    state_d     = GUARD;
                    cnt_d       = '0;
                    code_d      = CODE_NONE;
                    fav_stage_d = ~owner_q;
                    dlev_d      = bus.spi_done & ~owner_q;
                    dstg_d      = bus.spi_done & owner_q;
                    err_d       = ~bus.spi_done;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                code_d  = CODE_NONE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.SPI_Code    = code_q;
    assign bus.spi_start   = start_q;
    assign bus.done_lev    = dlev_q;
    assign bus.done_stage  = dstg_q;
    assign bus.err_timeout = err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_slave_scheduler.sv
// Randomized transaction-level check of spi_slave_scheduler.
// Expected timelines come from the schedule arithmetic, not the FSM.
module tb_spi_slave_scheduler;
    localparam int S = 2;
    localparam int G = 3;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   fav_stage = 1'b0;
    int   prev_start = -100;

    spi_slave_scheduler_if #(.CODE_SIZE(2)) bus ();

    spi_slave_scheduler #(
        .CODE_SIZE(2),
        .SETUP_CYCLES(S),
        .GUARD_CYCLES(G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.spi_done = 1'b0;
        chk("code_never_11", 32'(bus.SPI_Code == 2'b11), 0);
    endtask

    task automatic chk_quiet(input string tag, input logic [1:0] code);
        chk({tag, "_code"}, bus.SPI_Code, code);
        chk({tag, "_dlev"}, bus.done_lev, 0);
        chk({tag, "_dstg"}, bus.done_stage, 0);
        chk({tag, "_err"}, bus.err_timeout, 0);
    endtask

    // One full transaction starting from an IDLE cycle.
    // dly = XFER cycle index carrying spi_done (>= T means never).
    task automatic txn(input bit rl, input bit rs, input int dly,
                       input bit drop, input bit noise);
        bit own_stage;
        bit ok;
        logic [1:0] code;
        chk("idle_busy", bus.busy, 0);
        own_stage = (rl && rs) ? fav_stage : rs;
        code = own_stage ? 2'd2 : 2'd1;
        ok = (dly < T);
        bus.req_lev = rl;
        bus.req_stage = rs;
        step();
        if (drop) begin
            bus.req_lev = 1'b0;
            bus.req_stage = 1'b0;
        end
        for (int i = 0; i < S; i++) begin
            chk_quiet("setup", code);
            chk("setup_start", bus.spi_start, 0);
            chk("setup_busy", bus.busy, 1);
            if (noise) bus.spi_done = 1'b1;
            step();
        end
        chk_quiet("start", code);
        chk("start_pulse", bus.spi_start, 1);
        if (prev_start >= 0)
            chk("start_gap", 32'(cyc - prev_start >= S + G + 3), 1);
        prev_start = cyc;
        if (noise) bus.spi_done = 1'b1;
        step();
        for (int k = 0; k < T; k++) begin
            chk_quiet("xfer", code);
            chk("xfer_start", bus.spi_start, 0);
            if (k == dly) bus.spi_done = 1'b1;
            step();
            if (k == dly) break;
        end
        chk("gentry_code", bus.SPI_Code, 0);
        chk("gentry_dlev", bus.done_lev, 32'(ok && !own_stage));
        chk("gentry_dstg", bus.done_stage, 32'(ok && own_stage));
        chk("gentry_err", bus.err_timeout, 32'(!ok));
        chk("gentry_busy", bus.busy, 1);
        fav_stage = !own_stage;
        if (noise) bus.spi_done = 1'b1;
        step();
        for (int g = 1; g < G; g++) begin
            chk_quiet("guard", 2'd0);
            chk("guard_busy", bus.busy, 1);
            if (noise) bus.spi_done = 1'b1;
            step();
        end
        chk_quiet("idle", 2'd0);
        chk("idle_start", bus.spi_start, 0);
    endtask

    initial begin
        bus.req_lev = 1'b0;
        bus.req_stage = 1'b0;
        bus.spi_done = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk_quiet("reset", 2'd0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_start", bus.spi_start, 0);
        rst = 1'b0;

        // lone lev request, done on cycle 10
        txn(1'b1, 1'b0, 6, 1'b1, 1'b0);
        step();
        chk("post_idle_busy", bus.busy, 0);

        // both held from idle: strict alternation and minimum gap
        prev_start = -100;
        for (int n = 0; n < 4; n++)
            txn(1'b1, 1'b1, 0, 1'b0, 1'b0);
        bus.req_lev = 1'b0;
        bus.req_stage = 1'b0;
        step();
        prev_start = -100;

        // stage timeout, then lev wins a tie
        txn(1'b0, 1'b1, T + 5, 1'b1, 1'b0);
        txn(1'b1, 1'b1, 3, 1'b1, 1'b0);
        // done at terminal count, noise outside XFER
        txn(1'b1, 1'b0, T - 1, 1'b1, 1'b1);
        txn(1'b0, 1'b1, T - 1, 1'b1, 1'b1);

        // reset in the middle of a stage transfer
        bus.req_stage = 1'b1;
        step();
        bus.req_stage = 1'b0;
        for (int i = 0; i < S + 2; i++) step();
        chk("pre_rst_code", bus.SPI_Code, 2);
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_quiet("mid_rst", 2'd0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_start", bus.spi_start, 0);
        fav_stage = 1'b0;
        prev_start = -100;
        txn(1'b1, 1'b1, 2, 1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            int gap;
            int rq;
            gap = int'($urandom_range(0, 2));
            bus.req_lev = 1'b0;
            bus.req_stage = 1'b0;
            for (int i = 0; i < gap; i++) begin
                step();
                chk("rand_idle_busy", bus.busy, 0);
                prev_start = -100;
            end
            rq = int'($urandom_range(1, 3));
            txn(rq[0], rq[1], int'($urandom_range(0, T + 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        bus.req_lev = 1'b0;
        bus.req_stage = 1'b0;
        step();
        chk("final_busy", bus.busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
